spi_mem_master: RTL and testbench



---
 rtl/spi_mem_master.sv | 136 +++++++++++++
 tb/tb_spi_mem_master.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_master.sv
// SPI mode-0 initiator for single 40-bit mailbox transactions (1 write/cmd bit, 7 addr bits, 32 data bits).
// Latency: done at 1+81*CLK_DIV+CS_HOLD clocks after accept; no queueing, cmd_ready is low while a frame runs.
module spi_mem_master #(
  parameter int CLK_DIV = 4,
  parameter int CS_HOLD = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [6:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        done,
  output logic [31:0] rsp_rdata,
  output logic        busy,
  output logic        spi_clk,
  output logic        spi_cs,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int CMAX = (2 * CLK_DIV > CS_HOLD) ? 2 * CLK_DIV : CS_HOLD;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_DIV  = CW'(CLK_DIV);
  localparam logic [CW-1:0] C_DIV2 = CW'(2 * CLK_DIV);
  localparam logic [CW-1:0] C_HOLD = CW'(CS_HOLD);
  localparam logic [CW-1:0] C_GAP  = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [5:0]    bit_cnt;
  logic [39:0]   shreg;
  logic [31:0]   rx;
  logic          is_write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx        <= '0;
      is_write  <= 1'b0;
      spi_clk   <= 1'b0;
      spi_cs    <= 1'b1;
      spi_mosi  <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
      rsp_rdata <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            shreg     <= {cmd_write, cmd_addr, cmd_write ? cmd_wdata : 32'h0};
            is_write  <= cmd_write;
            cnt       <= '0;
            bit_cnt   <= '0;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          spi_cs   <= 1'b0;
          spi_mosi <= shreg[39];
          if (cnt == C_DIV) begin
            spi_clk <= 1'b1;
            cnt     <= C_ONE;
            state   <= SHIFT;
          end else begin
            cnt <= cnt + C_ONE;
          end
        end
        // cnt 1..CLK_DIV is the high phase, CLK_DIV+1..2*CLK_DIV the low phase
        SHIFT: begin
          if (cnt == C_DIV) begin
            spi_clk <= 1'b0;
            if (!is_write && bit_cnt >= 6'd8) rx <= {rx[30:0], spi_miso};
            if (bit_cnt != 6'd39) begin
              spi_mosi <= shreg[38];
              shreg    <= {shreg[38:0], 1'b0};
            end
            cnt <= cnt + C_ONE;
          end else if (cnt == C_DIV2) begin
            cnt <= C_ONE;
            if (bit_cnt == 6'd39) begin
              state <= HOLD;
            end else begin
              spi_clk <= 1'b1;
              bit_cnt <= bit_cnt + 6'd1;
            end
          end else begin
            cnt <= cnt + C_ONE;
          end
        end
        HOLD: begin
          if (cnt == C_HOLD) begin
            spi_cs   <= 1'b1;
            spi_mosi <= 1'b0;
            done     <= 1'b1;
            if (!is_write) rsp_rdata <= rx;
            cnt      <= C_ONE;
            state    <= GAP;
          end else begin
            cnt <= cnt + C_ONE;
          end
        end
        // IDLE is entered one clock early so the next accept edge lands CLK_DIV clocks after cs rises
        GAP: begin
          if (cnt == C_GAP) begin
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + C_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mem_master.sv
// Directed bench for spi_mem_master: two instances (CLK_DIV=4/CS_HOLD=2 and CLK_DIV=2/CS_HOLD=1),
// each with a polled mailbox slave that answers reads and commits complete write frames.
module tb_spi_mem_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n_w     [2];
  logic        cmd_valid_w [2];
  logic        cmd_write_w [2];
  logic [6:0]  cmd_addr_w  [2];
  logic [31:0] cmd_wdata_w [2];
  logic        cmd_ready_w [2];
  logic        done_w      [2];
  logic [31:0] rdata_w     [2];
  logic        busy_w      [2];
  logic        sclk_w      [2];
  logic        cs_w        [2];
  logic        mosi_w      [2];
  logic        miso_w      [2];

  spi_mem_master #(.CLK_DIV(4), .CS_HOLD(2)) u_dut0 (
    .clk(clk), .reset_n(rst_n_w[0]),
    .cmd_valid(cmd_valid_w[0]), .cmd_ready(cmd_ready_w[0]), .cmd_write(cmd_write_w[0]),
    .cmd_addr(cmd_addr_w[0]), .cmd_wdata(cmd_wdata_w[0]),
    .done(done_w[0]), .rsp_rdata(rdata_w[0]), .busy(busy_w[0]),
    .spi_clk(sclk_w[0]), .spi_cs(cs_w[0]), .spi_mosi(mosi_w[0]), .spi_miso(miso_w[0])
  );

  spi_mem_master #(.CLK_DIV(2), .CS_HOLD(1)) u_dut1 (
    .clk(clk), .reset_n(rst_n_w[1]),
    .cmd_valid(cmd_valid_w[1]), .cmd_ready(cmd_ready_w[1]), .cmd_write(cmd_write_w[1]),
    .cmd_addr(cmd_addr_w[1]), .cmd_wdata(cmd_wdata_w[1]),
    .done(done_w[1]), .rsp_rdata(rdata_w[1]), .busy(busy_w[1]),
    .spi_clk(sclk_w[1]), .spi_cs(cs_w[1]), .spi_mosi(mosi_w[1]), .spi_miso(miso_w[1])
  );

  // Monitor/slave state, written only by the negedge block below.
  logic [31:0] mbox [2][128];
  logic [39:0] s_rx [2];
  logic [39:0] last_frm [2];
  logic [31:0] s_tx [2];
  logic        s_wr [2];
  logic        p_cs [2] = '{1'b1, 1'b1};
  logic        p_clk [2] = '{1'b0, 1'b0};
  int s_bits [2], last_bits [2], acc_cnt [2], acc_edge [2], done_cnt [2], done_edge [2];
  int cs_fall_edge [2], cs_rise_edge [2], first_rise [2], prev_rise [2], last_rise [2];
  int hi_run [2], gap_run [2];
  bit loaded = 1'b0;

  always @(negedge clk) begin
    if (!loaded) begin
      for (int d = 0; d < 2; d++) begin
        for (int a = 0; a < 128; a++) mbox[d][a] = 32'h0;
        miso_w[d] = 1'b1;
        s_rx[d]   = '0;
        s_tx[d]   = '0;
        s_wr[d]   = 1'b0;
      end
      mbox[0][7'h7F] = 32'hA5A50F0F;
      mbox[0][7'h12] = 32'h13572468;
      mbox[1][7'h33] = 32'h0BADF00D;
      loaded = 1'b1;
    end
    for (int d = 0; d < 2; d++) begin
      if (cmd_valid_w[d] && cmd_ready_w[d]) begin
        acc_edge[d] = cyc + 1;
        acc_cnt[d]++;
      end
      if (done_w[d]) begin
        done_edge[d] = cyc;
        done_cnt[d]++;
      end
      if (!cs_w[d] && p_cs[d]) begin
        cs_fall_edge[d] = cyc;
        gap_run[d]      = hi_run[d];
        s_bits[d]       = 0;
        s_rx[d]         = '0;
        miso_w[d]       = 1'b1;
      end
      if (cs_w[d] && !p_cs[d]) begin
        cs_rise_edge[d] = cyc;
        last_frm[d]     = s_rx[d];
        last_bits[d]    = s_bits[d];
        if (s_bits[d] == 40 && s_rx[d][39]) mbox[d][s_rx[d][38:32]] = s_rx[d][31:0];
      end
      hi_run[d] = cs_w[d] ? hi_run[d] + 1 : 0;
      if (!cs_w[d] && sclk_w[d] && !p_clk[d]) begin
        if (s_bits[d] == 0) first_rise[d] = cyc;
        prev_rise[d] = last_rise[d];
        last_rise[d] = cyc;
        s_rx[d]      = {s_rx[d][38:0], mosi_w[d]};
        s_bits[d]++;
        if (s_bits[d] == 8) begin
          s_wr[d] = s_rx[d][7];
          s_tx[d] = mbox[d][s_rx[d][6:0]];
        end
      end
      if (!cs_w[d] && !sclk_w[d] && p_clk[d]) begin
        if (!s_wr[d] && s_bits[d] >= 8 && s_bits[d] <= 39) miso_w[d] = s_tx[d][5'(39 - s_bits[d])];
        else miso_w[d] = 1'b1;
      end
      p_cs[d]  = cs_w[d];
      p_clk[d] = sclk_w[d];
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command, scramble the cmd_* inputs after acceptance, wait for done and for cmd_ready.
  task automatic xact(input int d, input logic wr, input logic [6:0] a, input logic [31:0] wd);
    int a0, d0, n;
    a0 = acc_cnt[d];
    d0 = done_cnt[d];
    cmd_write_w[d] = wr;
    cmd_addr_w[d]  = a;
    cmd_wdata_w[d] = wd;
    cmd_valid_w[d] = 1'b1;
    n = 0;
    while (acc_cnt[d] == a0 && n < 1000) begin step(); n++; end
    cmd_valid_w[d] = 1'b0;
    cmd_write_w[d] = ~wr;
    cmd_addr_w[d]  = ~a;
    cmd_wdata_w[d] = ~wd;
    n = 0;
    while (done_cnt[d] == d0 && n < 1000) begin step(); n++; end
    chk($sformatf("xact%0d_done_count", d), 64'(done_cnt[d] - d0), 64'(1));
    n = 0;
    while (!cmd_ready_w[d] && n < 50) begin step(); n++; end
  endtask

  initial begin
    int a0, d0, n, acc1;
    for (int d = 0; d < 2; d++) begin
      rst_n_w[d]     = 1'b0;
      cmd_valid_w[d] = 1'b0;
      cmd_write_w[d] = 1'b0;
      cmd_addr_w[d]  = '0;
      cmd_wdata_w[d] = '0;
    end
    repeat (3) step();
    chk("rst0_outs", 64'({cs_w[0], sclk_w[0], mosi_w[0], done_w[0], busy_w[0]}), 64'(5'b10000));
    chk("rst0_rdata", 64'(rdata_w[0]), 64'(0));
    rst_n_w[0] = 1'b1;
    rst_n_w[1] = 1'b1;
    step();
    chk("rst0_ready", 64'(cmd_ready_w[0]), 64'(1));
    chk("rst1_outs", 64'({cs_w[1], sclk_w[1], mosi_w[1], done_w[1], busy_w[1], cmd_ready_w[1]}),
        64'(6'b100001));

    // Read 0x7F, wdata input must be ignored; header miso=1 must be discarded.
    xact(0, 1'b0, 7'h7F, 32'hFFFFFFFF);
    chk("rd7f_frame", 64'(last_frm[0]), 64'(40'h7F00000000));
    chk("rd7f_bits", 64'(last_bits[0]), 64'(40));
    chk("rd7f_rdata", 64'(rdata_w[0]), 64'(32'hA5A50F0F));
    chk("rd7f_done_lat", 64'(done_edge[0] - acc_edge[0]), 64'(327));

    xact(0, 1'b0, 7'h12, 32'h0);
    chk("rd12_rdata", 64'(rdata_w[0]), 64'(32'h13572468));

    // Write 0x12 <- DEADBEEF with full timing checks; rsp_rdata must keep the previous read.
    xact(0, 1'b1, 7'h12, 32'hDEADBEEF);
    chk("wr12_frame", 64'(last_frm[0]), 64'(40'h92DEADBEEF));
    chk("wr12_bits", 64'(last_bits[0]), 64'(40));
    chk("wr12_done_lat", 64'(done_edge[0] - acc_edge[0]), 64'(327));
    chk("wr12_cs_fall", 64'(cs_fall_edge[0] - acc_edge[0]), 64'(1));
    chk("wr12_first_rise", 64'(first_rise[0] - acc_edge[0]), 64'(5));
    chk("wr12_cs_rise", 64'(cs_rise_edge[0] - acc_edge[0]), 64'(327));
    chk("wr12_sclk_period", 64'(last_rise[0] - prev_rise[0]), 64'(8));
    chk("wr12_rdata_held", 64'(rdata_w[0]), 64'(32'h13572468));

    xact(0, 1'b0, 7'h12, 32'h0);
    chk("rd12_after_wr", 64'(rdata_w[0]), 64'(32'hDEADBEEF));

    // Back-to-back: valid held high, command changed to a read right after the first accept.
    a0 = acc_cnt[0];
    d0 = done_cnt[0];
    cmd_write_w[0] = 1'b1;
    cmd_addr_w[0]  = 7'h05;
    cmd_wdata_w[0] = 32'h11112222;
    cmd_valid_w[0] = 1'b1;
    n = 0;
    while (acc_cnt[0] == a0 && n < 1000) begin step(); n++; end
    acc1 = acc_edge[0];
    cmd_write_w[0] = 1'b0;
    cmd_wdata_w[0] = 32'h0;
    step();
    chk("b2b_busy_ready", 64'({busy_w[0], cmd_ready_w[0]}), 64'(2'b10));
    n = 0;
    while (done_cnt[0] == d0 && n < 1000) begin step(); n++; end
    chk("b2b_frame1", 64'(last_frm[0]), 64'(40'h8511112222));
    n = 0;
    while (acc_cnt[0] == a0 + 1 && n < 1000) begin step(); n++; end
    cmd_valid_w[0] = 1'b0;
    chk("b2b_spacing", 64'(acc_edge[0] - acc1), 64'(331));
    n = 0;
    while (done_cnt[0] == d0 + 1 && n < 1000) begin step(); n++; end
    chk("b2b_cs_gap_ge4", 64'(gap_run[0] >= 4), 64'(1));
    chk("b2b_frame2", 64'(last_frm[0]), 64'(40'h0500000000));
    chk("b2b_rdata", 64'(rdata_w[0]), 64'(32'h11112222));
    chk("b2b_done_count", 64'(done_cnt[0] - d0), 64'(2));
    n = 0;
    while (!cmd_ready_w[0] && n < 50) begin step(); n++; end

    // Abort a write to 0x7F during bit period 20 (spi_clk and mosi both high there).
    a0 = acc_cnt[0];
    cmd_write_w[0] = 1'b1;
    cmd_addr_w[0]  = 7'h7F;
    cmd_wdata_w[0] = 32'hFFFFFFFF;
    cmd_valid_w[0] = 1'b1;
    n = 0;
    while (acc_cnt[0] == a0 && n < 1000) begin step(); n++; end
    cmd_valid_w[0] = 1'b0;
    n = 0;
    while (s_bits[0] != 21 && n < 1000) begin step(); n++; end
    chk("abort_pre_sclk_mosi", 64'({sclk_w[0], mosi_w[0], busy_w[0]}), 64'(3'b111));
    d0 = done_cnt[0];
    rst_n_w[0] = 1'b0;
    #1;
    chk("abort_outs", 64'({cs_w[0], sclk_w[0], mosi_w[0], done_w[0], busy_w[0]}), 64'(5'b10000));
    chk("abort_rdata", 64'(rdata_w[0]), 64'(0));
    repeat (3) step();
    rst_n_w[0] = 1'b1;
    step();
    chk("abort_ready", 64'(cmd_ready_w[0]), 64'(1));
    repeat (400) step();
    chk("abort_no_done", 64'(done_cnt[0] - d0), 64'(0));
    xact(0, 1'b0, 7'h7F, 32'h0);
    chk("abort_next_rdata", 64'(rdata_w[0]), 64'(32'hA5A50F0F));
    chk("abort_next_lat", 64'(done_edge[0] - acc_edge[0]), 64'(327));

    // CLK_DIV=2 / CS_HOLD=1 instance.
    xact(1, 1'b0, 7'h33, 32'h0);
    chk("div2_frame", 64'(last_frm[1]), 64'(40'h3300000000));
    chk("div2_rdata", 64'(rdata_w[1]), 64'(32'h0BADF00D));
    chk("div2_done_lat", 64'(done_edge[1] - acc_edge[1]), 64'(164));
    chk("div2_first_rise", 64'(first_rise[1] - acc_edge[1]), 64'(3));
    chk("div2_sclk_period", 64'(last_rise[1] - prev_rise[1]), 64'(4));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
